// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the data_memory port between the CPU and an AUX master,
//            one access at a time. Macro DMEM_ARB_RR_EN enables round-robin.
// Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_sign,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  input  logic [1:0]            aux_size,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [1:0]            mem_size,
  output logic                  mem_sign,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

  state_t                  state, state_nxt;
  logic [2:0]              lat_cnt, lat_cnt_nxt;
  logic                    owner_aux, owner_aux_nxt;
  logic                    we_l, we_l_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_nxt;
  logic [1:0]              size_nxt;
  logic                    sign_nxt;
  logic                    re_nxt, we_nxt;
  logic                    cpu_gnt_nxt, aux_gnt_nxt;
  logic                    cpu_rvalid_nxt, aux_rvalid_nxt;
  logic [DATA_WIDTH-1:0]   cpu_rdata_nxt, aux_rdata_nxt;
  logic                    pick_cpu;
  logic                    sel_we;

`ifdef DMEM_ARB_RR_EN
  // last_aux = 1 means AUX won the previous arbitration; a tie goes to the other side.
  logic last_aux, last_aux_nxt;

  assign pick_cpu = cpu_req & (~aux_req | last_aux);

  always_comb begin
    last_aux_nxt = last_aux;
    if (state == IDLE && (cpu_req | aux_req)) begin
      last_aux_nxt = ~pick_cpu;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_aux <= 1'b1;
    end else begin
      last_aux <= last_aux_nxt;
    end
  end
`else
  assign pick_cpu = cpu_req;
`endif

  assign sel_we = pick_cpu ? cpu_we : aux_we;

  // Stall clears in the grant cycle of a store and in the response cycle of a load.
  assign cpu_stall = reset & cpu_req & ~(cpu_gnt & we_l) & ~cpu_rvalid;

  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    owner_aux_nxt  = owner_aux;
    we_l_nxt       = we_l;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    size_nxt       = mem_size;
    sign_nxt       = mem_sign;
    re_nxt         = 1'b0;
    we_nxt         = 1'b0;
    cpu_gnt_nxt    = 1'b0;
    aux_gnt_nxt    = 1'b0;
    cpu_rvalid_nxt = 1'b0;
    aux_rvalid_nxt = 1'b0;
    cpu_rdata_nxt  = cpu_rdata;
    aux_rdata_nxt  = aux_rdata;
    case (state)
      IDLE: begin
        if (cpu_req | aux_req) begin
          owner_aux_nxt = ~pick_cpu;
          we_l_nxt      = sel_we;
          addr_nxt      = pick_cpu ? cpu_addr  : aux_addr;
          wdata_nxt     = pick_cpu ? cpu_wdata : aux_wdata;
          size_nxt      = pick_cpu ? cpu_size  : aux_size;
          sign_nxt      = pick_cpu & cpu_sign;
          re_nxt        = ~sel_we;
          we_nxt        = sel_we;
          cpu_gnt_nxt   = pick_cpu;
          aux_gnt_nxt   = ~pick_cpu;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (we_l) begin
          state_nxt = IDLE;
        end else begin
          lat_cnt_nxt = LAT_INIT;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 3'd0) begin
          if (owner_aux) begin
            aux_rdata_nxt  = mem_rdata;
            aux_rvalid_nxt = 1'b1;
          end else begin
            cpu_rdata_nxt  = mem_rdata;
            cpu_rvalid_nxt = 1'b1;
          end
          state_nxt = RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - 3'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      owner_aux  <= 1'b0;
      we_l       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= 2'b00;
      mem_sign   <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_gnt    <= 1'b0;
      aux_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      owner_aux  <= owner_aux_nxt;
      we_l       <= we_l_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      mem_size   <= size_nxt;
      mem_sign   <= sign_nxt;
      mem_re     <= re_nxt;
      mem_we     <= we_nxt;
      cpu_gnt    <= cpu_gnt_nxt;
      aux_gnt    <= aux_gnt_nxt;
      cpu_rvalid <= cpu_rvalid_nxt;
      aux_rvalid <= aux_rvalid_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      aux_rdata  <= aux_rdata_nxt;
    end
  end

endmodule
`default_nettype wire
